// File: rtl/tsn_sched_pkg.sv
// Shared types and helpers for the TSN egress transmission-selection schedulers.
package tsn_sched_pkg;

    localparam int unsigned NUM_TC      = 8;
    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned OH_MAX_W    = 64;
    localparam int unsigned OH_IDX_W    = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    // Binary index of a one-hot vector; an all-zero input maps to 0.
    function automatic logic [OH_IDX_W-1:0] onehot_to_idx(input logic [OH_MAX_W-1:0] oh);
        logic [OH_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < OH_MAX_W; i++) begin
            if (oh[i]) begin
                idx = idx | OH_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_encoder.sv
// Strict-priority encoder: index of the highest set request bit plus an any-set flag.
module prio_encoder #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx_c,
    output logic         any_c
);

    always_comb begin
        idx_c = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx_c = W'(i);
            end
        end
    end

    assign any_c = |req;

endmodule

// File: rtl/tx_sel_scheduler.sv
// Per-port egress transmission-selection scheduler with packet-granular grants and stall watchdog.
// Optional per-queue frame / stall statistics are built when TX_SEL_STATS_EN is defined.
module tx_sel_scheduler
    import tsn_sched_pkg::*;
#(
    parameter int unsigned NUM_QUEUES   = NUM_TC,
    parameter int unsigned IDX_W        = $clog2(NUM_QUEUES),
    parameter int unsigned STALL_CYCLES = 1024
) (
    input  logic                  axis_aclk,
    input  logic                  axis_resetn,
    input  logic                  sched_en,
    input  logic [NUM_QUEUES-1:0] queue_valid,
    input  logic [NUM_QUEUES-1:0] gate_open,
    input  logic                  tx_tvalid,
    input  logic                  tx_tready,
    input  logic                  tx_tlast,
    output logic [NUM_QUEUES-1:0] grant,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  stall_err
`ifdef TX_SEL_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [NUM_QUEUES*32-1:0] stat_frames,
    output logic [STALL_CNT_W-1:0]   stat_stalls
`endif
);

    localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(STALL_CYCLES - 1);

    sched_state_e             state_q, state_d;
    logic [NUM_QUEUES-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]         grant_idx_q, grant_idx_d;
    logic                     grant_valid_q, grant_valid_d;
    logic                     stall_err_q, stall_err_d;
    logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [NUM_QUEUES-1:0]    eligible_c;
    logic [IDX_W-1:0]         win_idx_c;
    logic                     win_any_c;
    logic [NUM_QUEUES-1:0]    win_onehot_c;
    logic                     beat_acc_c;
    logic                     arb_c;
    logic                     rel_c;

    assign eligible_c   = queue_valid & gate_open;
    assign beat_acc_c   = tx_tvalid & tx_tready;
    assign win_onehot_c = NUM_QUEUES'(1) << win_idx_c;

    prio_encoder #(
        .N (NUM_QUEUES),
        .W (IDX_W)
    ) u_prio_encoder (
        .req   (eligible_c),
        .idx_c (win_idx_c),
        .any_c (win_any_c)
    );

    // Next-state: arbitrate only from IDLE or on the tlast beat; otherwise the grant is frozen.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        stall_err_d   = 1'b0;
        stall_cnt_d   = stall_cnt_q;
        arb_c         = 1'b0;
        rel_c         = 1'b0;

        case (state_q)
            IDLE: begin
                stall_cnt_d = '0;
                if (sched_en && win_any_c) begin
                    arb_c = 1'b1;
                end
            end
            GRANT: begin
                if (beat_acc_c) begin
                    stall_cnt_d = '0;
                    if (tx_tlast) begin
                        if (sched_en && win_any_c) begin
                            arb_c = 1'b1;
                        end else begin
                            rel_c = 1'b1;
                        end
                    end
                end else if (stall_cnt_q >= STALL_LAST) begin
                    rel_c       = 1'b1;
                    stall_err_d = 1'b1;
                    stall_cnt_d = '0;
                end else if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
                end
            end
            default: begin
                rel_c = 1'b1;
            end
        endcase

        if (arb_c) begin
            state_d       = GRANT;
            grant_d       = win_onehot_c;
            grant_idx_d   = IDX_W'(onehot_to_idx(OH_MAX_W'(win_onehot_c)));
            grant_valid_d = 1'b1;
            stall_cnt_d   = '0;
        end else if (rel_c) begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_idx_d   = '0;
            grant_valid_d = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            stall_err_q   <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            stall_err_q   <= stall_err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign stall_err   = stall_err_q;

`ifdef TX_SEL_STATS_EN
    logic [NUM_QUEUES*32-1:0] stat_frames_q, stat_frames_d;
    logic [STALL_CNT_W-1:0]   stat_stalls_q, stat_stalls_d;
    logic                     frame_done_c;

    assign frame_done_c = (state_q == GRANT) & beat_acc_c & tx_tlast;

    // Clear takes precedence over a coincident increment.
    always_comb begin
        stat_frames_d = stat_frames_q;
        stat_stalls_d = stat_stalls_q;
        if (stat_clr) begin
            stat_frames_d = '0;
            stat_stalls_d = '0;
        end else begin
            if (frame_done_c) begin
                stat_frames_d[32'(grant_idx_q)*32 +: 32] =
                    stat_frames_q[32'(grant_idx_q)*32 +: 32] + 32'd1;
            end
            if (stall_err_d && (stat_stalls_q != '1)) begin
                stat_stalls_d = stat_stalls_q + STALL_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            stat_frames_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule
